// File: rtl/lap_timer_if.sv
// Control and display bundle between the button/mode logic (master) and lap_timer (slave).
interface lap_timer_if #(
    parameter int LAP_DEPTH = 4
);
    localparam int CW = $clog2(LAP_DEPTH + 1);

    logic          start;
    logic          stop;
    logic          zero;
    logic          down;
    logic          load;
    logic [6:0]    load_min;
    logic [5:0]    load_sec;
    logic [9:0]    load_msec;
    logic          lap;
    logic          lap_pop;
    logic          running;
    logic [6:0]    min;
    logic [5:0]    sec;
    logic [9:0]    msec;
    logic          expired;
    logic [6:0]    lap_min;
    logic [5:0]    lap_sec;
    logic [9:0]    lap_msec;
    logic          lap_valid;
    logic [CW-1:0] lap_count;
    logic          lap_drop;

    modport master (
        output start, stop, zero, down, load, load_min, load_sec, load_msec, lap, lap_pop,
        input  running, min, sec, msec, expired, lap_min, lap_sec, lap_msec,
               lap_valid, lap_count, lap_drop
    );

    modport slave (
        input  start, stop, zero, down, load, load_min, load_sec, load_msec, lap, lap_pop,
        output running, min, sec, msec, expired, lap_min, lap_sec, lap_msec,
               lap_valid, lap_count, lap_drop
    );
endinterface

// File: rtl/lap_timer.sv
// min:sec:msec up/down timer with millisecond prescaler and a first-word-fall-through lap FIFO.
module lap_timer #(
    parameter int CLKS_PER_MS = 1,
    parameter int MIN_MAX     = 99,
    parameter int LAP_DEPTH   = 4
) (
    input logic        clk,
    input logic        rst,
    lap_timer_if.slave bus
);
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);

    logic [PW-1:0]                 r_presc, w_presc;
    logic                          r_running, w_running;
    logic                          r_dir, w_dir;
    logic [6:0]                    r_min, w_min, w_up_min, w_dn_min;
    logic [5:0]                    r_sec, w_sec, w_up_sec, w_dn_sec;
    logic [9:0]                    r_msec, w_msec, w_up_msec, w_dn_msec;
    logic                          r_expired, w_expired;
    logic                          r_drop, w_drop;
    logic                          r_valid, w_valid;
    logic [CW-1:0]                 r_count, w_count, w_widx;
    logic [LAP_DEPTH-1:0][22:0]    r_fifo, w_fifo;
    logic                          w_tick, w_time_zero, w_dn_last, w_full, w_do_pop, w_do_push;

    assign w_tick      = r_running && (r_presc == PW'(CLKS_PER_MS - 1));
    assign w_time_zero = (r_min == 7'd0) && (r_sec == 6'd0) && (r_msec == 10'd0);
    assign w_dn_last   = (r_min == 7'd0) && (r_sec == 6'd0) && (r_msec == 10'd1);

    // One-millisecond increment and decrement of the current time with carry/borrow.
    always_comb begin
        w_up_min  = r_min;
        w_up_sec  = r_sec;
        w_up_msec = r_msec + 10'd1;
        w_dn_min  = r_min;
        w_dn_sec  = r_sec;
        w_dn_msec = r_msec - 10'd1;
        if (r_msec == 10'd999) begin
            w_up_msec = 10'd0;
            if (r_sec == 6'd59) begin
                w_up_sec = 6'd0;
                w_up_min = (r_min == 7'(MIN_MAX)) ? 7'd0 : r_min + 7'd1;
            end else begin
                w_up_sec = r_sec + 6'd1;
            end
        end else begin
            w_up_msec = r_msec + 10'd1;
        end
        if (r_msec == 10'd0) begin
            w_dn_msec = 10'd999;
            if (r_sec == 6'd0) begin
                w_dn_sec = 6'd59;
                w_dn_min = (r_min == 7'd0) ? 7'(MIN_MAX) : r_min - 7'd1;
            end else begin
                w_dn_sec = r_sec - 6'd1;
            end
        end else begin
            w_dn_msec = r_msec - 10'd1;
        end
    end

    // Control priority zero > load > stop > start > tick.
    always_comb begin
        w_presc   = r_presc;
        w_running = r_running;
        w_dir     = r_dir;
        w_min     = r_min;
        w_sec     = r_sec;
        w_msec    = r_msec;
        w_expired = 1'b0;
        if (bus.zero) begin
            w_presc   = '0;
            w_running = 1'b0;
            w_min     = 7'd0;
            w_sec     = 6'd0;
            w_msec    = 10'd0;
        end else if (bus.load && !r_running) begin
            w_presc = '0;
            w_min   = (bus.load_min > 7'(MIN_MAX)) ? 7'(MIN_MAX) : bus.load_min;
            w_sec   = (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;
            w_msec  = (bus.load_msec > 10'd999) ? 10'd999 : bus.load_msec;
        end else if (bus.stop) begin
            w_running = 1'b0;
        end else if (bus.start && !r_running) begin
            if (!(bus.down && w_time_zero)) begin
                w_running = 1'b1;
                w_dir     = bus.down;
            end else begin
                w_running = 1'b0;
            end
        end else if (w_tick) begin
            w_presc = '0;
            if (r_dir) begin
                w_min  = w_dn_min;
                w_sec  = w_dn_sec;
                w_msec = w_dn_msec;
                if (w_dn_last) begin
                    w_running = 1'b0;
                    w_expired = 1'b1;
                end else begin
                    w_running = 1'b1;
                end
            end else begin
                w_min  = w_up_min;
                w_sec  = w_up_sec;
                w_msec = w_up_msec;
            end
        end else if (r_running) begin
            w_presc = r_presc + PW'(1);
        end else begin
            w_presc = r_presc;
        end
    end

    assign w_full    = (r_count == CW'(LAP_DEPTH));
    assign w_do_pop  = bus.lap_pop && (r_count != '0);
    assign w_do_push = bus.lap && (!w_full || w_do_pop);
    assign w_widx    = r_count - CW'(w_do_pop);

    // Lap FIFO as a shift register: entry 0 is the head, unused entries held at zero.
    always_comb begin
        w_fifo  = r_fifo;
        w_count = r_count;
        w_drop  = 1'b0;
        if (bus.zero) begin
            w_fifo  = '0;
            w_count = '0;
        end else begin
            if (w_do_pop) begin
                for (int i = 0; i < LAP_DEPTH - 1; i++) begin
                    w_fifo[i] = r_fifo[i+1];
                end
                w_fifo[LAP_DEPTH-1] = 23'd0;
            end else begin
                w_fifo = r_fifo;
            end
            for (int i = 0; i < LAP_DEPTH; i++) begin
                if (w_do_push && (CW'(i) == w_widx)) begin
                    w_fifo[i] = {r_min, r_sec, r_msec};
                end else begin
                    w_fifo[i] = w_fifo[i];
                end
            end
            w_drop  = bus.lap && !w_do_push;
            w_count = r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
        w_valid = (w_count != '0);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_running <= 1'b0;
            r_dir     <= 1'b0;
            r_min     <= 7'd0;
            r_sec     <= 6'd0;
            r_msec    <= 10'd0;
            r_expired <= 1'b0;
            r_drop    <= 1'b0;
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_fifo    <= '0;
        end else begin
            r_presc   <= w_presc;
            r_running <= w_running;
            r_dir     <= w_dir;
            r_min     <= w_min;
            r_sec     <= w_sec;
            r_msec    <= w_msec;
            r_expired <= w_expired;
            r_drop    <= w_drop;
            r_valid   <= w_valid;
            r_count   <= w_count;
            r_fifo    <= w_fifo;
        end
    end

    assign bus.running   = r_running;
    assign bus.min       = r_min;
    assign bus.sec       = r_sec;
    assign bus.msec      = r_msec;
    assign bus.expired   = r_expired;
    assign bus.lap_min   = r_fifo[0][22:16];
    assign bus.lap_sec   = r_fifo[0][15:10];
    assign bus.lap_msec  = r_fifo[0][9:0];
    assign bus.lap_valid = r_valid;
    assign bus.lap_count = r_count;
    assign bus.lap_drop  = r_drop;
endmodule
